// File: rtl/hyperram_pkg.sv
// hyperram_pkg: shared state encoding and default timing for the HyperRAM CK/CS sequencer
package hyperram_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_RUN,
      ST_HOLD,
      ST_RECOVER
   } seq_state_e;

   localparam int HR_CSS_CYCLES = 2;
   localparam int HR_CSH_CYCLES = 1;
   localparam int HR_RWR_CYCLES = 6;
   localparam int HR_CNT_W      = 12;

endpackage

// File: rtl/hyperram_ck_sequencer.sv
// hyperram_ck_sequencer: frames each HyperRAM transaction with CS#, tCSS, gated CK, tCSH and tRWR
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   transaction handshake, req_len = CK cycles to generate
//   abort                 end the CK burst early (honoured in SETUP/RUN only)
//   ck_en, cs_n           clock-gate enable and chip select to the pads
//   busy, done            not idle; one-cycle pulse as CS# deasserts
module hyperram_ck_sequencer
   import hyperram_pkg::*;
#(
   parameter int CSS_CYCLES = HR_CSS_CYCLES,
   parameter int CSH_CYCLES = HR_CSH_CYCLES,
   parameter int RWR_CYCLES = HR_RWR_CYCLES,
   parameter int CNT_W      = HR_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [CNT_W-1:0] req_len,
   input  logic             abort,
   output logic             ck_en,
   output logic             cs_n,
   output logic             busy,
   output logic             done
);

   localparam logic [CNT_W-1:0] CSS_LOAD = CNT_W'(CSS_CYCLES - 1);
   localparam logic [CNT_W-1:0] CSH_LOAD = CNT_W'(CSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] RWR_LOAD = CNT_W'(RWR_CYCLES - 1);

   seq_state_e       state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx, len_q;
   logic             ck_en_nx, cs_n_nx, ready_nx, busy_nx, done_nx;
   logic             accept, cnt_zero;

   assign accept   = req_valid & req_ready;
   assign cnt_zero = cnt == '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         len_q     <= '0;
         ck_en     <= 1'b0;
         cs_n      <= 1'b1;
         req_ready <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         len_q     <= accept ? req_len : len_q;
         ck_en     <= ck_en_nx;
         cs_n      <= cs_n_nx;
         req_ready <= ready_nx;
         busy      <= busy_nx;
         done      <= done_nx;
      end
   end

   // Every transition reloads the counter, so the default decrement never wraps.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt - 1'b1;
      case (state)
         ST_IDLE: begin
            state_nx = accept ? ST_SETUP : ST_IDLE;
            cnt_nx   = accept ? CSS_LOAD : cnt;
         end
         ST_SETUP: begin
            if (abort || (cnt_zero && len_q == '0)) begin
               state_nx = ST_HOLD;
               cnt_nx   = CSH_LOAD;
            end else if (cnt_zero) begin
               state_nx = ST_RUN;
               cnt_nx   = len_q - 1'b1;
            end
         end
         ST_RUN: begin
            if (abort || cnt_zero) begin
               state_nx = ST_HOLD;
               cnt_nx   = CSH_LOAD;
            end
         end
         ST_HOLD: begin
            if (cnt_zero) begin
               state_nx = ST_RECOVER;
               cnt_nx   = RWR_LOAD;
            end
         end
         ST_RECOVER: begin
            if (cnt_zero) begin
               state_nx = ST_IDLE;
               cnt_nx   = '0;
            end
         end
         default: begin
            state_nx = ST_IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   // Outputs are the decode of the next state, registered alongside it.
   always_comb begin
      ck_en_nx = state_nx == ST_RUN;
      cs_n_nx  = state_nx == ST_IDLE || state_nx == ST_RECOVER;
      ready_nx = state_nx == ST_IDLE;
      busy_nx  = state_nx != ST_IDLE;
      done_nx  = state == ST_HOLD && state_nx == ST_RECOVER;
   end

endmodule

// File: tb/tb_hyperram_ck_sequencer.sv
// tb_hyperram_ck_sequencer: vector table plus scoreboard checks of CS#/CK framing, abort and reset
module tb_hyperram_ck_sequencer;

   localparam int CNT_W = 12;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             req_valid = 1'b0;
   logic             abort = 1'b0;
   logic [CNT_W-1:0] req_len = '0;
   logic             req_ready, ck_en, cs_n, busy, done;

   int checks = 0;
   int failures = 0;

   typedef struct {
      int len;
      int abort_at;
      int ck_first;
      int ck_cnt;
      int cs_last;
      int done_at;
      int ready_at;
   } vec_t;

   vec_t sb[$];
   vec_t vecs[11];

   always #5 clk = ~clk;

   hyperram_ck_sequencer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_len   (req_len),
      .abort     (abort),
      .ck_en     (ck_en),
      .cs_n      (cs_n),
      .busy      (busy),
      .done      (done)
   );

   always @(negedge clk) begin
      if (ck_en && cs_n) begin
         failures++;
         $display("FAIL ck_en_without_cs at %0t: ck_en=%0b cs_n=%0b required cs_n=0", $time, ck_en, cs_n);
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic wait_ready(input int limit);
      for (int i = 0; i < limit && !req_ready; i++) @(negedge clk);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int ck_first = 0, ck_cnt = 0, cs_last = 0, done_at = 0, done_cnt = 0, ready_at = 0, busy1 = 0;
      vec_t e;
      wait_ready(20);
      req_len = CNT_W'(v.len);
      req_valid = 1'b1;
      @(posedge clk);
      sb.push_back(v);
      for (int k = 1; k <= 5000 && ready_at == 0; k++) begin
         @(negedge clk);
         if (k == 1) begin
            req_valid = 1'b0;
            busy1 = int'(busy);
         end
         if (ck_en) begin
            if (ck_first == 0) ck_first = k;
            ck_cnt++;
         end
         if (!cs_n) cs_last = k;
         if (done) begin
            done_cnt++;
            if (done_at == 0) done_at = k;
         end
         if (req_ready) ready_at = k;
         abort = (k == v.abort_at);
      end
      abort = 1'b0;
      e = sb.pop_front();
      check($sformatf("v%0d_busy", idx), busy1, 1);
      check($sformatf("v%0d_ck_first", idx), ck_first, e.ck_first);
      check($sformatf("v%0d_ck_cnt", idx), ck_cnt, e.ck_cnt);
      check($sformatf("v%0d_cs_last", idx), cs_last, e.cs_last);
      check($sformatf("v%0d_done_at", idx), done_at, e.done_at);
      check($sformatf("v%0d_done_cnt", idx), done_cnt, 1);
      check($sformatf("v%0d_ready_at", idx), ready_at, e.ready_at);
   endtask

   initial begin
      #2000000;
      failures++;
      $display("FAIL watchdog expired");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

   initial begin
      int prev_cs, frames, gap, f2_low, ck_tot, done_cnt, f2_start, dcnt;
      vecs = '{
         '{4,    0, 3, 4,    7,    8,    14},
         '{0,    0, 0, 0,    3,    4,    10},
         '{100,  5, 3, 3,    6,    7,    13},
         '{1,    0, 3, 1,    4,    5,    11},
         '{50,   1, 0, 0,    2,    3,    9},
         '{50,   2, 0, 0,    3,    4,    10},
         '{4,    6, 3, 4,    7,    8,    14},
         '{4,    7, 3, 4,    7,    8,    14},
         '{4,    9, 3, 4,    7,    8,    14},
         '{2,    0, 3, 2,    5,    6,    12},
         '{4095, 0, 3, 4095, 4098, 4099, 4105}
      };
      #1 rst_n = 1'b0;
      #2;
      check("rst_ck_en", int'(ck_en), 0);
      check("rst_cs_n", int'(cs_n), 1);
      check("rst_ready", int'(req_ready), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

      // back-to-back with req_valid held high
      wait_ready(20);
      req_len = 12'd2;
      req_valid = 1'b1;
      @(posedge clk);
      prev_cs = 1; frames = 0; gap = 0; f2_low = 0; ck_tot = 0; done_cnt = 0; f2_start = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 1) req_len = 12'd3;
         if (!cs_n && prev_cs == 1) begin
            frames++;
            if (frames == 2) f2_start = k;
         end
         if (cs_n && frames == 1) gap++;
         if (!cs_n && frames == 2) f2_low++;
         if (ck_en) ck_tot++;
         if (done) done_cnt++;
         if (frames == 2) req_valid = 1'b0;
         prev_cs = int'(cs_n);
      end
      check("b2b_frames", frames, 2);
      check("b2b_second_start", f2_start, 13);
      check("b2b_cs_high_gap", gap, 7);
      check("b2b_second_cs_low", f2_low, 6);
      check("b2b_ck_total", ck_tot, 5);
      check("b2b_done_cnt", done_cnt, 2);
      check("b2b_idle_ready", int'(req_ready), 1);
      check("b2b_idle_busy", int'(busy), 0);

      // abort while idle must not block an accept
      abort = 1'b1;
      req_valid = 1'b1;
      req_len = 12'd3;
      @(posedge clk);
      @(negedge clk);
      abort = 1'b0;
      req_valid = 1'b0;
      check("idle_abort_cs_n", int'(cs_n), 0);
      check("idle_abort_busy", int'(busy), 1);
      ck_tot = 0;
      for (int i = 0; i < 30 && !req_ready; i++) begin
         @(negedge clk);
         if (ck_en) ck_tot++;
      end
      check("idle_abort_ck_cnt", ck_tot, 3);
      check("idle_abort_ready", int'(req_ready), 1);

      // asynchronous reset in the middle of RUN
      req_len = 12'd10;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk) req_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_run_ck_en", int'(ck_en), 1);
      #2 rst_n = 1'b0;
      #1;
      check("areset_ck_en", int'(ck_en), 0);
      check("areset_cs_n", int'(cs_n), 1);
      check("areset_ready", int'(req_ready), 1);
      check("areset_busy", int'(busy), 0);
      dcnt = 0;
      repeat (2) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      check("areset_no_done", dcnt, 0);
      rst_n = 1'b1;
      req_valid = 1'b1;
      req_len = 12'd2;
      @(posedge clk);
      @(negedge clk) req_valid = 1'b0;
      check("post_reset_cs_n", int'(cs_n), 0);
      check("post_reset_busy", int'(busy), 1);
      dcnt = 0;
      for (int i = 0; i < 30 && !req_ready; i++) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      check("post_reset_done", dcnt, 1);
      check("post_reset_ready", int'(req_ready), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
